// File: rtl/viterbi_pkg.sv
// Shared types and code parameters for the rate-1/2 convolutional encoder
// and the Viterbi decoder datapath (BM/ACS, branch-label generation).
package viterbi_pkg;

  // Constraint length; the encoder shift register holds K-1 past bits.
  localparam int unsigned K = 3;

  // Generators: bit K-1 taps the current input, bit K-2 the newest past bit.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Tail counter wide enough to hold K-1.
  localparam int unsigned TAIL_W = $clog2(K);

  typedef logic [1:0]        sym_t;
  typedef logic [K-2:0]      enc_state_t;
  typedef logic [TAIL_W-1:0] tail_cnt_t;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } enc_fsm_t;

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity network: (input bit, encoder state) -> code symbol.
// Also used by the decoder to generate expected branch labels.
//   in_bit : current information bit
//   sr     : past bits, sr[K-2] newest
//   sym_c  : {c0 (G0), c1 (G1)}
module conv_enc_parity
  import viterbi_pkg::*;
(
  input  logic       in_bit,
  input  enc_state_t sr,
  output sym_t       sym_c
);

  logic [K-1:0] v;

  assign v     = {in_bit, sr};
  assign sym_c = {^(v & G0), ^(v & G1)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready handshakes and
// a single registered output slot. Frames are zero-terminated with K-1 tail
// symbols so the decoder traceback starts from state 0.
// Macro CONV_ENC_TAIL_EN: when defined, each frame is followed by K-1 tail
// symbols (N bits -> N+K-1 symbols); when undefined there is no tail, o_last
// marks the symbol of the i_last bit and the state is cleared on that fire.
// Ports:
//   i_clk, i_rst_n    : clock (rising edge), asynchronous active-low reset
//   i_bit/i_last      : information bit and end-of-frame flag, qualified by i_valid
//   o_ready           : encoder accepts an input this cycle
//   o_sym/o_last      : code symbol and end-of-frame flag, qualified by o_valid
//   i_ready           : downstream accepts o_sym this cycle
//   o_busy            : frame in progress (first bit accepted .. last symbol handed off)
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  input  logic i_valid,
  input  logic i_last,
  output logic o_ready,
  output sym_t o_sym,
  output logic o_valid,
  output logic o_last,
  input  logic i_ready,
  output logic o_busy
);

  enc_fsm_t   state_q, state_d;
  enc_state_t sr_q, sr_d;
  sym_t       sym_q, sym_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
`ifdef CONV_ENC_TAIL_EN
  tail_cnt_t  tail_cnt_q, tail_cnt_d;
`endif

  logic out_free;
  logic in_fire;
  logic out_fire;
  logic enc_in;
  sym_t par_sym_c;

  // Output slot can take a new symbol if empty or being drained this cycle.
  assign out_free = !valid_q | i_ready;
  assign o_ready  = (state_q == ST_DATA) & out_free;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = valid_q & i_ready;

  // Tail symbols encode a forced zero input.
  assign enc_in   = (state_q == ST_DATA) ? i_bit : 1'b0;

  conv_enc_parity u_parity (
    .in_bit (enc_in),
    .sr     (sr_q),
    .sym_c  (par_sym_c)
  );

  // Next-state and output-slot logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sym_d   = sym_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef CONV_ENC_TAIL_EN
    tail_cnt_d = tail_cnt_q;
`endif

    // Drain first so a same-cycle refill (and a new frame's busy) wins.
    if (out_fire) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (last_q) begin
        busy_d = 1'b0;
      end
    end

    case (state_q)
      ST_DATA: begin
        if (in_fire) begin
          sym_d   = par_sym_c;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
          sr_d    = enc_state_t'({i_bit, sr_q} >> 1);
          if (i_last) begin
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_d = tail_cnt_t'(K - 1);
            state_d    = ST_TAIL;
`else
            last_d = 1'b1;
            sr_d   = '0;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      ST_TAIL: begin
        // Flush zeros; the state register returns to 0 after K-1 symbols.
        if (out_free) begin
          sym_d      = par_sym_c;
          valid_d    = 1'b1;
          sr_d       = enc_state_t'({1'b0, sr_q} >> 1);
          tail_cnt_d = tail_cnt_q - tail_cnt_t'(1);
          if (tail_cnt_q == tail_cnt_t'(1)) begin
            last_d  = 1'b1;
            state_d = ST_DATA;
          end
        end
      end
`endif
      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_DATA;
      sr_q    <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q <= tail_cnt_d;
`endif
    end
  end

  assign o_sym   = sym_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a per-cycle vector table with
// hand-computed symbols, then scoreboard-checked streams (stalls, back-to-back
// frames, reset mid-frame, random frames). Expectations follow the build's
// CONV_ENC_TAIL_EN setting.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_bit, i_valid, i_last, i_ready;
  logic       o_ready, o_valid, o_last, o_busy;
  logic [1:0] o_sym;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_encoder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_bit   (i_bit),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_sym   (o_sym),
    .o_valid (o_valid),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  typedef struct {
    logic       vin, b, l, rdy;
    logic       exp_ready, exp_valid;
    logic [1:0] exp_sym;
    logic       exp_last, exp_busy;
  } vec_t;

  typedef struct packed { logic b; logic l; } in_t;
  typedef struct packed { logic [1:0] sym; logic l; } exp_t;

  in_t        in_q[$];
  exp_t       exp_q[$];
  logic [1:0] m_sr;
  logic       busy_m;
  logic       pending_tail;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference encoder: v = {b, sr}, c0 = parity(v & 7), c1 = parity(v & 5).
  task automatic push_exp(input logic b, input logic l);
    exp_t       e;
    logic [2:0] v;
    v     = {b, m_sr};
    e.sym = {^(v & 3'b111), ^(v & 3'b101)};
    e.l   = l;
    exp_q.push_back(e);
    m_sr  = {b, m_sr[1]};
  endtask

  task automatic model_fire(input in_t t);
    if (!t.l) begin
      push_exp(t.b, 1'b0);
    end else begin
`ifdef CONV_ENC_TAIL_EN
      push_exp(t.b, 1'b0);
      push_exp(1'b0, 1'b0);
      push_exp(1'b0, 1'b1);
      pending_tail = 1'b1;
`else
      push_exp(t.b, 1'b1);
      m_sr = 2'b00;
`endif
    end
  endtask

  // Drive in_q through the DUT; vmode 0 = continuous valid, else random.
  // rmode 0 = ready high, 1 = toggling, 2 = random.
  task automatic run_stream(input string tag, input int vmode, input int rmode);
    int   cyc;
    logic tog;
    logic fin, fout;
    in_t  t;
    cyc = 0;
    tog = 1'b0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 20000) begin
      if (in_q.size() != 0 && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
        i_valid = 1'b1;
        i_bit   = in_q[0].b;
        i_last  = in_q[0].l;
      end else begin
        i_valid = 1'b0;
        i_bit   = 1'($urandom);
        i_last  = 1'b0;
      end
      case (rmode)
        0:       i_ready = 1'b1;
        1:       begin i_ready = !tog; tog = !tog; end
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
      #2;
      fin  = i_valid & o_ready;
      fout = o_valid & i_ready;
      if (o_valid && o_last) pending_tail = 1'b0;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          fail_now({tag, "_extra_sym"});
        end else begin
          chk2({tag, "_sym"}, o_sym, exp_q[0].sym);
          chk1({tag, "_last"}, o_last, exp_q[0].l);
        end
      end
      chk1({tag, "_busy"}, o_busy, busy_m);
      if (pending_tail) chk1({tag, "_tail_ready"}, o_ready, 1'b0);
      if (o_valid && !i_ready) chk1({tag, "_stall_ready"}, o_ready, 1'b0);
      if (fout && exp_q.size() != 0) begin
        if (exp_q[0].l) busy_m = 1'b0;
        void'(exp_q.pop_front());
      end
      if (fin) begin
        t      = in_q.pop_front();
        busy_m = 1'b1;
        model_fire(t);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 20000) fail_now({tag, "_timeout"});
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    #2;
    chk1({tag, "_drain_valid"}, o_valid, 1'b0);
    chk1({tag, "_drain_busy"}, o_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] bits, input int n);
    in_t e;
    for (int i = 0; i < n; i++) begin
      e.b = bits[i];
      e.l = (i == n - 1);
      in_q.push_back(e);
    end
  endtask

`ifdef CONV_ENC_TAIL_EN
  localparam int NV = 16;
`else
  localparam int NV = 10;
`endif

  vec_t vecs[16];

  initial begin
    logic [3:0] rb;
    int         n_pre;
    int         len;
    in_t        e;

    // {vin, b, l, rdy, exp_ready, exp_valid, exp_sym, exp_last, exp_busy}
`ifdef CONV_ENC_TAIL_EN
    vecs[0]  = '{1, 1, 0, 1, 1, 1, 2'b11, 0, 1};
    vecs[1]  = '{1, 0, 0, 1, 1, 1, 2'b10, 0, 1};
    vecs[2]  = '{1, 1, 0, 1, 1, 1, 2'b00, 0, 1};
    vecs[3]  = '{1, 1, 1, 1, 1, 1, 2'b01, 0, 1};
    vecs[4]  = '{0, 0, 0, 1, 0, 1, 2'b01, 0, 1};
    vecs[5]  = '{0, 0, 0, 1, 0, 1, 2'b11, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
    vecs[7]  = '{1, 1, 1, 1, 1, 1, 2'b11, 0, 1};
    vecs[8]  = '{0, 0, 0, 1, 0, 1, 2'b10, 0, 1};
    vecs[9]  = '{0, 0, 0, 1, 0, 1, 2'b11, 1, 1};
    vecs[10] = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
    vecs[11] = '{1, 0, 1, 0, 1, 1, 2'b00, 0, 1};
    vecs[12] = '{1, 1, 0, 0, 0, 1, 2'b00, 0, 1};
    vecs[13] = '{0, 0, 0, 1, 0, 1, 2'b00, 0, 1};
    vecs[14] = '{0, 0, 0, 1, 0, 1, 2'b00, 1, 1};
    vecs[15] = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
`else
    vecs[0]  = '{1, 1, 0, 1, 1, 1, 2'b11, 0, 1};
    vecs[1]  = '{1, 0, 0, 1, 1, 1, 2'b10, 0, 1};
    vecs[2]  = '{1, 1, 0, 1, 1, 1, 2'b00, 0, 1};
    vecs[3]  = '{1, 1, 1, 1, 1, 1, 2'b01, 1, 1};
    vecs[4]  = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 1, 1, 2'b11, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
    vecs[7]  = '{1, 0, 1, 0, 1, 1, 2'b00, 1, 1};
    vecs[8]  = '{1, 1, 0, 0, 0, 1, 2'b00, 1, 1};
    vecs[9]  = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
    for (int i = 10; i < 16; i++) vecs[i] = '{0, 0, 0, 1, 1, 0, 2'b00, 0, 0};
`endif

    // Reset state.
    rst_n   = 1'b0;
    i_bit   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    m_sr         = 2'b00;
    busy_m       = 1'b0;
    pending_tail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk2("rst_sym", o_sym, 2'b00);
    chk1("rst_last", o_last, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_ready", o_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed per-cycle table.
    for (int i = 0; i < NV; i++) begin
      i_valid = vecs[i].vin;
      i_bit   = vecs[i].b;
      i_last  = vecs[i].l;
      i_ready = vecs[i].rdy;
      #2;
      chk1($sformatf("tbl%0d_ready", i), o_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      chk1($sformatf("tbl%0d_valid", i), o_valid, vecs[i].exp_valid);
      chk1($sformatf("tbl%0d_last", i), o_last, vecs[i].exp_last);
      chk1($sformatf("tbl%0d_busy", i), o_busy, vecs[i].exp_busy);
      if (vecs[i].exp_valid) chk2($sformatf("tbl%0d_sym", i), o_sym, vecs[i].exp_sym);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;

    // Frame 1,0,1,1 with i_ready toggling every cycle.
    push_frame(4'b1101, 4);
    run_stream("toggle", 0, 1);

    // Back-to-back frames {1} then {1,1}, continuous valid.
    push_frame(4'b0001, 1);
    push_frame(4'b0011, 2);
    run_stream("b2b", 0, 0);

    // Reset in the middle of a frame (during the tail when it exists).
    rb = 4'b1101;
`ifdef CONV_ENC_TAIL_EN
    n_pre = 5;
`else
    n_pre = 2;
`endif
    i_ready = 1'b1;
    for (int i = 0; i < n_pre; i++) begin
      i_valid = (i < 4);
      i_bit   = (i < 4) ? rb[i] : 1'b0;
      i_last  = (i == 3);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk1("pre_rst_valid", o_valid, 1'b1);
    chk1("pre_rst_busy", o_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", o_valid, 1'b0);
    chk1("mid_rst_last", o_last, 1'b0);
    chk1("mid_rst_busy", o_busy, 1'b0);
    chk1("mid_rst_ready", o_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_sr         = 2'b00;
    busy_m       = 1'b0;
    pending_tail = 1'b0;
    push_frame(4'b1101, 4);
    run_stream("post_rst", 0, 0);

    // Random frames with random valid/ready, including one-bit frames.
    for (int f = 0; f < 5; f++) begin
      len = (f == 1) ? 1 : $urandom_range(1, 250);
      for (int i = 0; i < len; i++) begin
        e.b = 1'($urandom);
        e.l = (i == len - 1);
        in_q.push_back(e);
      end
    end
    run_stream("rand", 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
